// File: rtl/sw_mailbox_tx.sv
// Host-side byte transmitter feeding the core's switch input through a small FIFO and a 4-phase req/ack handshake.
// Optional per-phase handshake timeout is enabled by defining SWTX_TIMEOUT_EN.
`timescale 1ns/1ps

module sw_mailbox_tx #(
    parameter int DEPTH       = 8,
    parameter int ACK_BIT     = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_tx_data,
    input  logic        i_tx_valid,
    output logic        o_tx_ready,
    input  logic [31:0] i_io_ledr,
    output logic [31:0] o_io_sw,
    output logic        o_busy,
    output logic [15:0] o_sent_cnt,
    output logic        o_timeout
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        RELEASE
    } state_t;

    state_t      state;
    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        ack_q;
    logic        req_q;
    logic [7:0]  data_q;
    logic [15:0] sent_q;
    logic        more;
    logic        unused_ledr;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign push       = i_tx_valid && !full;
    // The FIFO head leaves only when the FSM commits to presenting it.
    assign pop        = (state == IDLE) && !empty;
    assign o_tx_ready = !full;
    assign o_busy     = (state != IDLE) || !empty;
    assign more       = req_q && !empty;
    assign o_io_sw    = {22'b0, more, req_q, data_q};
    assign o_sent_cnt = sent_q;
    assign unused_ledr = ^i_io_ledr;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_tx_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // One register stage on the ack decouples the core's LEDR timing from the FSM.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= i_io_ledr[ACK_BIT];
        end
    end

`ifdef SWTX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] phase_cnt;
    logic          phase_hit;
    logic          timeout_q;

    assign phase_hit = (phase_cnt == TW'(TIMEOUT_CYC - 1));
    assign o_timeout = timeout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
    assign o_timeout          = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state  <= IDLE;
            req_q  <= 1'b0;
            data_q <= 8'h00;
            sent_q <= 16'h0000;
`ifdef SWTX_TIMEOUT_EN
            phase_cnt <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef SWTX_TIMEOUT_EN
            phase_cnt <= (state == IDLE) ? '0 : phase_cnt + TW'(1);
`endif
            case (state)
                IDLE: begin
                    if (pop) begin
                        data_q <= mem[rd_ptr];
                        req_q  <= 1'b1;
                        state  <= PRESENT;
`ifdef SWTX_TIMEOUT_EN
                        phase_cnt <= '0;
`endif
                    end
                end
                PRESENT: begin
                    if (ack_q) begin
                        req_q  <= 1'b0;
                        sent_q <= sent_q + 16'd1;
                        state  <= RELEASE;
`ifdef SWTX_TIMEOUT_EN
                        phase_cnt <= '0;
                    end else if (phase_hit) begin
                        // Abandon the byte without counting it; queued bytes still go out.
                        req_q     <= 1'b0;
                        state     <= IDLE;
                        timeout_q <= 1'b1;
                        phase_cnt <= '0;
`endif
                    end
                end
                RELEASE: begin
                    if (!ack_q) begin
                        state <= IDLE;
`ifdef SWTX_TIMEOUT_EN
                        phase_cnt <= '0;
                    end else if (phase_hit) begin
                        state     <= IDLE;
                        timeout_q <= 1'b1;
                        phase_cnt <= '0;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sw_mailbox_tx.sv
// Self-checking bench for sw_mailbox_tx: a scoreboard queue of pushed bytes is compared against each presentation.
// Define SWTX_TIMEOUT_EN on both files to exercise the timeout path.
`timescale 1ns/1ps

module tb_sw_mailbox_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [31:0] ledr = 32'h0;
    logic [31:0] io_sw;
    logic        busy;
    logic [15:0] sent_cnt;
    logic        timeout;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  exp_q[$];
    int          exp_sent = 0;

    sw_mailbox_tx #(
        .DEPTH      (8),
        .ACK_BIT    (8),
        .TIMEOUT_CYC(16)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_tx_data (tx_data),
        .i_tx_valid(tx_valid),
        .o_tx_ready(tx_ready),
        .i_io_ledr (ledr),
        .o_io_sw   (io_sw),
        .o_busy    (busy),
        .o_sent_cnt(sent_cnt),
        .o_timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    // Bounded wait for req to reach a level; an expired bound counts as a miscompare.
    task automatic wait_req(input logic level, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (io_sw[8] === level) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL wait_req: req stuck at %b, required %b", io_sw[8], level);
        end
    endtask

    // Acts as the core: capture the presented byte, ack it, drop the ack, let the FSM return to IDLE.
    task automatic serve_byte(output logic [7:0] data, output logic more, output bit ok);
        data = 8'hxx;
        more = 1'bx;
        wait_req(1'b1, ok);
        if (!ok) return;
        data = io_sw[7:0];
        more = io_sw[9];
        ledr[8] = 1'b1;
        wait_req(1'b0, ok);
        ledr[8] = 1'b0;
        if (ok) exp_sent++;
        tick(2);
    endtask

    task automatic test_reset_idle;
        vectors++;
        if (io_sw !== 32'h0 || tx_ready !== 1'b1 || busy !== 1'b0 || sent_cnt !== 16'h0 || timeout !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_idle: sw=%h ready=%b busy=%b cnt=%0d to=%b, required 0/1/0/0/0",
                     io_sw, tx_ready, busy, sent_cnt, timeout);
        end
    endtask

    task automatic test_single_byte;
        push_byte(8'h41);
        vectors++;
        if (io_sw !== 32'h0 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_early: sw=%h busy=%b, required 00000000/1", io_sw, busy);
        end
        tick();
        vectors++;
        if (io_sw !== 32'h0000_0141) begin
            miscompares++;
            $display("[TB] FAIL single_present: sw=%h, required 00000141", io_sw);
        end
        tick(2);
        ledr[8] = 1'b1;
        tick();
        vectors++;
        if (io_sw[8] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_ack_lag: req=%b, required 1", io_sw[8]);
        end
        tick();
        exp_sent++;
        vectors++;
        if (io_sw !== 32'h0000_0041 || sent_cnt !== 16'(exp_sent)) begin
            miscompares++;
            $display("[TB] FAIL single_release: sw=%h cnt=%0d, required 00000041/%0d", io_sw, sent_cnt, exp_sent);
        end
        ledr[8] = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_release_hold: busy=%b, required 1", busy);
        end
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_stream;
        logic [7:0] msg [3] = '{8'h48, 8'h69, 8'h0A};
        logic [7:0] got;
        logic       more;
        logic [7:0] want;
        bit         ok;
        foreach (msg[i]) begin
            push_byte(msg[i]);
            exp_q.push_back(msg[i]);
        end
        for (int i = 0; i < 3; i++) begin
            serve_byte(got, more, ok);
            if (!ok) break;
            want = exp_q.pop_front();
            vectors++;
            if (got !== want || more !== (exp_q.size() != 0)) begin
                miscompares++;
                $display("[TB] FAIL stream_byte%0d: data=%h more=%b, required %h/%b",
                         i, got, more, want, exp_q.size() != 0);
            end
        end
        exp_q.delete();
        vectors++;
        if (sent_cnt !== 16'(exp_sent)) begin
            miscompares++;
            $display("[TB] FAIL stream_count: cnt=%0d, required %0d", sent_cnt, exp_sent);
        end
    endtask

    task automatic test_fifo_full;
        logic [7:0] got;
        logic       more;
        logic [7:0] want;
        bit         ok;
        for (int b = 0; b < 9; b++) begin
            push_byte(8'(b));
            exp_q.push_back(8'(b));
        end
        vectors++;
        if (tx_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL full_ready: ready=%b, required 0", tx_ready);
        end
        push_byte(8'h09);
        for (int i = 0; i < 9; i++) begin
            serve_byte(got, more, ok);
            if (!ok) break;
            want = exp_q.pop_front();
            vectors++;
            if (got !== want || more !== (exp_q.size() != 0)) begin
                miscompares++;
                $display("[TB] FAIL full_byte%0d: data=%h more=%b, required %h/%b",
                         i, got, more, want, exp_q.size() != 0);
            end
        end
        exp_q.delete();
        tick(4);
        vectors++;
        if (io_sw[8] !== 1'b0 || busy !== 1'b0 || tx_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL full_drained: req=%b busy=%b ready=%b, required 0/0/1 (0x09 must be dropped)",
                     io_sw[8], busy, tx_ready);
        end
    endtask

    task automatic test_ack_held;
        logic [7:0] got;
        logic       more;
        bit         ok;
        int         stray;
        push_byte(8'h5A);
        wait_req(1'b1, ok);
        ledr[8] = 1'b1;
        wait_req(1'b0, ok);
        exp_sent++;
        push_byte(8'h5B);
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            if (io_sw[8] !== 1'b0) stray++;
            tick();
        end
        vectors++;
        if (stray != 0 || sent_cnt !== 16'(exp_sent)) begin
            miscompares++;
            $display("[TB] FAIL ack_held: req-high cycles=%0d cnt=%0d, required 0/%0d", stray, sent_cnt, exp_sent);
        end
        ledr[8] = 1'b0;
        serve_byte(got, more, ok);
        vectors++;
        if (got !== 8'h5B || sent_cnt !== 16'(exp_sent)) begin
            miscompares++;
            $display("[TB] FAIL ack_held_next: data=%h cnt=%0d, required 5b/%0d", got, sent_cnt, exp_sent);
        end
    endtask

    task automatic test_timeout;
        logic [7:0] got;
        logic       more;
        bit         ok;
        push_byte(8'h55);
        wait_req(1'b1, ok);
`ifdef SWTX_TIMEOUT_EN
        tick(15);
        vectors++;
        if (io_sw[8] !== 1'b1 || timeout !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout_early: req=%b to=%b, required 1/0", io_sw[8], timeout);
        end
        tick();
        vectors++;
        if (io_sw[8] !== 1'b0 || timeout !== 1'b1 || sent_cnt !== 16'(exp_sent)) begin
            miscompares++;
            $display("[TB] FAIL timeout_fire: req=%b to=%b cnt=%0d, required 0/1/%0d",
                     io_sw[8], timeout, sent_cnt, exp_sent);
        end
        push_byte(8'h66);
        serve_byte(got, more, ok);
        vectors++;
        if (got !== 8'h66 || timeout !== 1'b1 || sent_cnt !== 16'(exp_sent)) begin
            miscompares++;
            $display("[TB] FAIL timeout_next: data=%h to=%b cnt=%0d, required 66/1/%0d",
                     got, timeout, sent_cnt, exp_sent);
        end
`else
        tick(40);
        vectors++;
        if (io_sw[8] !== 1'b1 || timeout !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL no_timeout: req=%b to=%b, required 1/0", io_sw[8], timeout);
        end
        serve_byte(got, more, ok);
        vectors++;
        if (got !== 8'h55 || sent_cnt !== 16'(exp_sent)) begin
            miscompares++;
            $display("[TB] FAIL no_timeout_done: data=%h cnt=%0d, required 55/%0d", got, sent_cnt, exp_sent);
        end
`endif
    endtask

    task automatic test_reset_abort;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        exp_sent = 0;
        test_reset_idle();
        @(negedge clk);
        rst = 1'b0;
        tick(5);
        vectors++;
        if (io_sw !== 32'h0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_discard: sw=%h busy=%b, required 00000000/0", io_sw, busy);
        end
    endtask

    initial begin
        #2;
        test_reset_idle();
        tick(3);
        @(negedge clk);
        rst = 1'b0;
        tick();
        test_single_byte();
        tick(2);
        test_stream();
        tick(2);
        test_fifo_full();
        tick(2);
        test_ack_held();
        tick(2);
        test_timeout();
        tick(2);
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sw_mailbox_tx.md
Name: sw_mailbox_tx

Overview:
- Host-side character transmitter into the single-cycle core's switch input (i_io_sw); the complement of the bench scoreboard that receives characters from LEDR.
- Bytes pushed by the testbench are buffered in a small FIFO, then presented one at a time on o_io_sw under a 4-phase req/ack handshake.
- The program running on the core acknowledges each byte by writing the ack bit on LEDR.
- Lets ISA/IO programs consume input strings deterministically.

Parameters:
- DEPTH, 8: FIFO entries; power of 2, minimum 2.
- ACK_BIT, 8: index of the ack bit in i_io_ledr.
- TIMEOUT_CYC, 1024: cycles allowed per handshake phase. Used only with SWTX_TIMEOUT_EN.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_tx_data  input  8  byte to enqueue.
- i_tx_valid  input  1  enqueue request.
- o_tx_ready  output  1  FIFO can accept; push occurs when i_tx_valid and o_tx_ready are both 1.
- i_io_ledr  input  32  core LEDR output; bit ACK_BIT is the ack.
- o_io_sw  output  32  drives core i_io_sw.
  - [7:0] data.
  - [8] req.
  - [9] more (FIFO non-empty while req is high).
  - [31:10] always 0.
- o_busy  output  1  1 whenever state is not IDLE or the FIFO is non-empty.
- o_sent_cnt  output  16  count of completed handshakes.
- o_timeout  output  1  sticky handshake-timeout flag.

Behaviour:
- Reset (async assert): FIFO empty, state IDLE, ack_q=0, o_io_sw=0, o_sent_cnt=0, o_timeout=0, o_tx_ready=1, o_busy=0.
- ack_q: i_io_ledr[ACK_BIT] registered once. All ack decisions use ack_q, so the core's ack is seen 1 cycle after it appears.
- FIFO push/pop:
  - o_tx_ready = not full.
  - A push while full is ignored, including in a cycle where a pop also occurs.
  - Pop happens only on the IDLE->PRESENT transition.
  - Pointers wrap modulo DEPTH; an occupancy counter (0..DEPTH) distinguishes full from empty.
- State machine, states IDLE, PRESENT, RELEASE:
  - IDLE: if FIFO non-empty, pop the head. Next cycle: o_io_sw[7:0]=byte, [8]=1, [9]=(FIFO still non-empty after the pop); go to PRESENT. Latency from push into an empty FIFO in IDLE to req=1 is 2 cycles.
  - PRESENT: hold data and req. [9] tracks live FIFO non-empty. When ack_q=1: req->0, o_sent_cnt+=1, go to RELEASE.
  - RELEASE: req=0; data stays on [7:0]. When ack_q=0, go to IDLE.
  - A byte pushed while in RELEASE is presented no earlier than 2 cycles after returning to IDLE.
- ack_q=1 while in IDLE is ignored. A new req is never raised until ack_q has been seen low in RELEASE.
- o_sent_cnt wraps from 16'hFFFF to 0.
- A reset asserted mid-handshake aborts it. The in-flight byte and the FIFO contents are discarded.

Optional Feature:
- Macro: SWTX_TIMEOUT_EN.
- Defined:
  - A phase counter clears on every state change and increments while in PRESENT or RELEASE.
  - When it reaches TIMEOUT_CYC:
    - o_timeout<=1 (sticky until reset).
    - req<=0 and state<=IDLE.
    - The presented byte is dropped and o_sent_cnt is not incremented.
  - Remaining FIFO bytes continue to be sent.
- Not defined: no counter; o_timeout is tied to 0; handshakes wait indefinitely.

Test Plan:
- Reset check: assert i_reset mid-cycle with no clock edge -> immediately o_io_sw=0, o_tx_ready=1, o_busy=0, o_sent_cnt=0, o_timeout=0.
- Single byte:
  - Push 0x41 at cycle 0 -> cycle 2: o_io_sw=32'h0000_0141.
  - Set ledr[8]=1 at cycle 5 -> cycle 7: o_io_sw[8]=0, o_sent_cnt=1.
  - Clear ledr[8] -> state returns to IDLE 2 cycles later.
- Stream "Hi\n" (0x48, 0x69, 0x0A) with a responder acking each byte:
  - o_io_sw[9]=1, 1, 0 on the three presentations.
  - Bytes arrive in order; o_sent_cnt=3.
- FIFO full:
  - With no ack, push 10 bytes 0x00..0x09 -> 0x00 is presented; 0x01..0x08 fill the FIFO; o_tx_ready=0; 0x09 is rejected.
  - Acking all bytes yields exactly 0x00..0x08.
- Ack held high: keep ledr[8]=1 across a handshake -> no second req until ack is dropped; o_sent_cnt increments by exactly 1.
- Timeout (SWTX_TIMEOUT_EN, TIMEOUT_CYC=16):
  - Push 0x55 and never ack -> after 16 PRESENT cycles: req=0, o_timeout=1, o_sent_cnt=0.
  - Next byte 0x66 is presented normally.
  - Without the macro: req stays high and o_timeout=0.
